// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encoding,
// region limits and datapath widths.
package imem_loader_pkg;

    localparam int WORD_W           = 32;
    localparam int BYTE_W           = 8;
    localparam int ADDR_BITS_DEF    = 5;
    localparam int HANDLER_BASE_DEF = 28;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    // States in which the loader consumes stream bytes.
    function automatic logic is_active(input logic [2:0] st);
        return (st == ST_COUNT) || (st == ST_DATA) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer with a running XOR checksum over every
// shifted byte. word_o/word_full_o are valid in the cycle the 4th byte shifts.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              shift_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o,
    output logic [BYTE_W-1:0] checksum_o
);

    logic [WORD_W-BYTE_W-1:0] sr_q, sr_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [BYTE_W-1:0]        csum_q, csum_d;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        csum_d = csum_q;
        if (clear_i) begin
            sr_d   = '0;
            cnt_d  = '0;
            csum_d = '0;
        end else if (shift_en_i) begin
            sr_d   = {sr_q[WORD_W-2*BYTE_W-1:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
            csum_d = csum_q ^ byte_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            csum_q <= '0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            csum_q <= csum_d;
        end
    end

    // The completed word bypasses the register so it can be captured on the 4th byte.
    assign word_o      = {sr_q, byte_i};
    assign word_full_o = shift_en_i && !clear_i && (cnt_q == 2'd3);
    assign checksum_o  = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: count byte, N big-endian words, XOR
// checksum byte. Holds the CPU during the load and never touches the handler region.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_BITS    = ADDR_BITS_DEF,
    parameter int HANDLER_BASE = HANDLER_BASE_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemData,
    output logic        CpuHold,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [2:0]  StateDbg
);

    localparam logic [7:0]         MAX_WORDS = 8'(HANDLER_BASE);
    localparam logic [ADDR_BITS:0] BASE_IDX  = (ADDR_BITS+1)'(HANDLER_BASE);

    // Handshake: a byte transfers on a rising edge where ByteValid && ByteReady.
    // ByteReady is registered from the next state, so it is high exactly in
    // COUNT, DATA and CHECK; ByteIn is ignored whenever no transfer occurs.

    logic [2:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] widx_q, widx_d;
    logic [7:0]           left_q, left_d;
    logic                 ready_q, busy_q, hold_q, done_q, err_q, we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          data_q;

    logic                 xfer;
    logic                 pk_clear, pk_shift, pk_full;
    logic [31:0]          pk_word;
    logic [7:0]           pk_csum;
    logic                 write_ok;

    assign xfer     = ByteValid && ready_q;
    assign write_ok = pk_full && (state_q == ST_DATA) && ({1'b0, widx_q} < BASE_IDX);

    imem_word_packer u_packer (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .clear_i     (pk_clear),
        .shift_en_i  (pk_shift),
        .byte_i      (ByteIn),
        .word_o      (pk_word),
        .word_full_o (pk_full),
        .checksum_o  (pk_csum)
    );

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        left_d   = left_q;
        pk_clear = 1'b0;
        pk_shift = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (Start) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (xfer) begin
                    if (ByteIn == 8'd0 || ByteIn > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        widx_d   = '0;
                        left_d   = ByteIn;
                        pk_clear = 1'b1;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    pk_shift = 1'b1;
                    if (pk_full) begin
                        widx_d = widx_q + 1'b1;
                        left_d = left_q - 8'd1;
                        if (left_q == 8'd1) state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) state_d = (ByteIn == pk_csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            widx_q  <= '0;
            left_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            left_q  <= left_d;
            ready_q <= is_active(state_d);
            busy_q  <= is_active(state_d);
            hold_q  <= is_active(state_d) || (state_d == ST_ERR);
            done_q  <= (state_d == ST_DONE);
            err_q   <= (state_d == ST_ERR);
            we_q    <= write_ok;
            if (write_ok) begin
                addr_q <= widx_q;
                data_q <= pk_word;
            end
        end
    end

    assign ByteReady = ready_q;
    assign MemWe     = we_q;
    assign MemAddr   = {{(30-ADDR_BITS){1'b0}}, addr_q, 2'b00};
    assign MemData   = data_q;
    assign CpuHold   = hold_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = err_q;
    assign StateDbg  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, handshake bubbles, count limits,
// checksum failure, reset mid-load and Start while busy.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  ByteIn = 8'h00;
    logic        ByteValid = 1'b0;
    logic        ByteReady, MemWe, CpuHold, Busy, Done, Error;
    logic [31:0] MemAddr, MemData;
    logic [2:0]  StateDbg;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [31:0] last_wr_addr = '0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  stream[$];

    imem_loader dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .MemWe     (MemWe),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .CpuHold   (CpuHold),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .StateDbg  (StateDbg)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write scoreboard and Done counter, sampled on the falling edge.
    always @(negedge Clk) begin
        if (Done) done_cnt++;
        if (MemWe) begin
            wr_cnt++;
            last_wr_addr = MemAddr;
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", 32'd0, 32'd1);
            end else begin
                check("wr_addr", MemAddr, exp_addr_q.pop_front());
                check("wr_data", MemData, exp_data_q.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic build_case1(input logic [7:0] last);
        stream = '{8'h02, 8'h3c, 8'h01, 8'h11, 8'h11, 8'h3c, 8'h02, 8'h11, 8'h11, last};
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b, input logic s);
        int t = 0;
        ByteIn = b;
        ByteValid = 1'b1;
        Start = s;
        while (!ByteReady && t < 20) begin
            @(negedge Clk);
            t++;
        end
        if (!ByteReady) check("ready_timeout", 32'd0, 32'd1);
        @(negedge Clk);
        ByteValid = 1'b0;
        Start = 1'b0;
    endtask

    task automatic run_load(input int gap_max, input int start_idx);
        pulse_start();
        check("hold_after_start", {31'd0, CpuHold}, 32'd1);
        check("busy_after_start", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < stream.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(1, gap_max)) @(negedge Clk);
            send_byte(stream[i], i == start_idx);
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic expect_success(input string tag, input int w0, input int d0, input int nw);
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(nw));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_error"}, {31'd0, Error}, 32'd0);
        check({tag, "_hold"}, {31'd0, CpuHold}, 32'd0);
        check({tag, "_state"}, {29'd0, StateDbg}, {29'd0, ST_IDLE});
        check({tag, "_exp_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic expect_error(input string tag, input int w0, input int nw);
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(nw));
        check({tag, "_error"}, {31'd0, Error}, 32'd1);
        check({tag, "_hold"}, {31'd0, CpuHold}, 32'd1);
        check({tag, "_ready"}, {31'd0, ByteReady}, 32'd0);
        check({tag, "_state"}, {29'd0, StateDbg}, {29'd0, ST_ERR});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, {29'd0, StateDbg}, {29'd0, ST_IDLE});
        check({tag, "_outs"}, {25'd0, ByteReady, MemWe, CpuHold, Busy, Done, Error, 1'b0}, 32'd0);
        check({tag, "_addr"}, MemAddr, 32'd0);
        check({tag, "_data"}, MemData, 32'd0);
    endtask

    initial begin
        int w0, d0;
        logic [7:0] csum;
        logic [31:0] word;

        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);

        // 1: basic back-to-back load
        build_case1(8'h03);
        push_exp(32'h00, 32'h3c011111);
        push_exp(32'h04, 32'h3c021111);
        w0 = wr_cnt; d0 = done_cnt;
        run_load(0, -1);
        expect_success("basic", w0, d0, 2);

        // 2: valid bubbles between bytes
        push_exp(32'h00, 32'h3c011111);
        push_exp(32'h04, 32'h3c021111);
        w0 = wr_cnt; d0 = done_cnt;
        run_load(3, -1);
        expect_success("bubbles", w0, d0, 2);

        // 3: count limits
        stream = '{8'h1D};
        w0 = wr_cnt;
        run_load(0, -1);
        expect_error("count_1d", w0, 0);
        stream = '{8'h00};
        w0 = wr_cnt;
        run_load(0, -1);
        expect_error("count_00", w0, 0);

        stream = '{8'h1C};
        csum = 8'h00;
        for (int w = 0; w < 28; w++) begin
            word = {8'(w), 8'hC3, 8'(w * 7), 8'h5A};
            push_exp(32'(w * 4), word);
            for (int k = 3; k >= 0; k--) begin
                stream.push_back(word[k*8 +: 8]);
                csum = csum ^ word[k*8 +: 8];
            end
        end
        stream.push_back(csum);
        w0 = wr_cnt; d0 = done_cnt;
        run_load(0, -1);
        expect_success("count_1c", w0, d0, 28);
        check("count_1c_last_addr", last_wr_addr, 32'h6C);

        // 4: bad checksum, then recovery
        build_case1(8'h04);
        push_exp(32'h00, 32'h3c011111);
        push_exp(32'h04, 32'h3c021111);
        w0 = wr_cnt;
        run_load(0, -1);
        expect_error("bad_csum", w0, 2);
        build_case1(8'h03);
        push_exp(32'h00, 32'h3c011111);
        push_exp(32'h04, 32'h3c021111);
        w0 = wr_cnt; d0 = done_cnt;
        pulse_start();
        check("recover_err_clear", {31'd0, Error}, 32'd0);
        for (int i = 0; i < stream.size(); i++) send_byte(stream[i], 1'b0);
        repeat (3) @(negedge Clk);
        expect_success("recover", w0, d0, 2);

        // 5: reset after the 6th byte
        build_case1(8'h03);
        push_exp(32'h00, 32'h3c011111);
        w0 = wr_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0);
        Reset = 1'b1;
        @(negedge Clk);
        check_all_zero("mid_reset");
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("mid_reset_writes", 32'(wr_cnt - w0), 32'd1);
        check("mid_reset_exp_left", 32'(exp_addr_q.size()), 32'd0);
        push_exp(32'h00, 32'h3c011111);
        push_exp(32'h04, 32'h3c021111);
        w0 = wr_cnt; d0 = done_cnt;
        run_load(0, -1);
        expect_success("after_reset", w0, d0, 2);

        // 6: Start pulse during DATA is ignored
        push_exp(32'h00, 32'h3c011111);
        push_exp(32'h04, 32'h3c021111);
        w0 = wr_cnt; d0 = done_cnt;
        run_load(0, 4);
        expect_success("start_busy", w0, d0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
